// File: rtl/loop_mixer.sv
// loop_mixer: snapshots the live ADC sample per frame as SRAM write data,
// sums the read samples of playing banks, and emits one saturated DAC
// sample per frame when the memory controller signals mix_data.
module loop_mixer #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_100MHz,
    input  logic              rst,
    input  logic              pulse,
    input  logic [DATA_W-1:0] adc_sample,
    input  logic              adc_valid,
    input  logic              monitor_en,
    input  logic [15:0]       playing,
    input  logic [15:0]       recording,
    input  logic [3:0]        mem_bank,
    input  logic              data_ready,
    input  logic              mix_data,
    input  logic              write_zero,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] dac_sample,
    output logic              dac_valid,
    output logic              clip,
    output logic              overrun
);

    // 16 banks plus the live monitor term need 5 guard bits
    localparam int unsigned ACC_W = DATA_W + 5;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_d;
    logic [DATA_W-1:0]        in_hold;
    logic [DATA_W-1:0]        frame_in;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_load;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     hit;
    logic [DATA_W-1:0]        dac_sample_d;
    logic                     dac_valid_d;
    logic                     clip_d;
    logic                     overrun_d;

    // Input capture: latest ADC sample, frozen once per frame for recording
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            in_hold    <= '0;
            frame_in   <= '0;
            write_data <= '0;
        end else begin
            if (adc_valid) in_hold <= adc_sample;
            if (pulse)     frame_in <= in_hold;
            write_data <= write_zero ? '0 : frame_in;
        end
    end

    // Per-access contribution and frame start value
    always_comb begin
        hit      = data_ready & playing[mem_bank] & ~recording[mem_bank];
        acc_next = acc + (hit ? ACC_W'($signed(read_data)) : '0);
        acc_load = monitor_en ? ACC_W'($signed(in_hold)) : '0;
    end

    // State register
    always_ff @(posedge clk_100MHz) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state, accumulator and output-register next values
    always_comb begin
        state_d      = state;
        acc_d        = acc;
        dac_sample_d = dac_sample;
        dac_valid_d  = 1'b0;
        clip_d       = clip;
        overrun_d    = 1'b0;
        case (state)
            IDLE: begin
                if (pulse) begin
                    acc_d   = acc_load;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_next;
                if (mix_data) begin
                    state_d = SAT;
                end else if (pulse) begin
                    // frame never closed: discard it and restart
                    acc_d     = acc_load;
                    overrun_d = 1'b1;
                end
            end
            SAT: begin
                dac_valid_d = 1'b1;
                if (acc > SAT_MAX) begin
                    dac_sample_d = DATA_W'(SAT_MAX);
                    clip_d       = 1'b1;
                end else if (acc < SAT_MIN) begin
                    dac_sample_d = DATA_W'(SAT_MIN);
                    clip_d       = 1'b1;
                end else begin
                    dac_sample_d = DATA_W'(acc);
                    clip_d       = 1'b0;
                end
                if (pulse) begin
                    acc_d   = acc_load;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator and output registers
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            acc        <= '0;
            dac_sample <= '0;
            dac_valid  <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            acc        <= acc_d;
            dac_sample <= dac_sample_d;
            dac_valid  <= dac_valid_d;
            clip       <= clip_d;
            overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_loop_mixer.sv
// tb_loop_mixer: directed scenarios plus random traffic, every cycle checked
// against an integer-arithmetic frame model.
module tb_loop_mixer;

    localparam int unsigned DATA_W = 16;

    logic              clk_100MHz = 1'b0;
    logic              rst;
    logic              pulse;
    logic [DATA_W-1:0] adc_sample;
    logic              adc_valid;
    logic              monitor_en;
    logic [15:0]       playing;
    logic [15:0]       recording;
    logic [3:0]        mem_bank;
    logic              data_ready;
    logic              mix_data;
    logic              write_zero;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] dac_sample;
    logic              dac_valid;
    logic              clip;
    logic              overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_in_hold, m_frame_in, m_sum;
    bit m_open, m_pend;
    int e_wd, e_dac;
    bit e_valid, e_clip, e_ovr;

    always #5 clk_100MHz = ~clk_100MHz;

    loop_mixer #(.DATA_W(DATA_W)) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .pulse      (pulse),
        .adc_sample (adc_sample),
        .adc_valid  (adc_valid),
        .monitor_en (monitor_en),
        .playing    (playing),
        .recording  (recording),
        .mem_bank   (mem_bank),
        .data_ready (data_ready),
        .mix_data   (mix_data),
        .write_zero (write_zero),
        .read_data  (read_data),
        .write_data (write_data),
        .dac_sample (dac_sample),
        .dac_valid  (dac_valid),
        .clip       (clip),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp_v, $time);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic start_frame();
        m_sum  = monitor_en ? m_in_hold : 0;
        m_open = 1'b1;
    endtask

    // Advance one clock: predict from current inputs, then compare all outputs
    task automatic step();
        int  rd;
        bit  hit;
        rd  = int'($signed(read_data));
        hit = data_ready && playing[mem_bank] && !recording[mem_bank];
        e_valid = 1'b0;
        e_ovr   = 1'b0;
        if (rst) begin
            m_in_hold = 0; m_frame_in = 0; m_sum = 0;
            m_open = 1'b0; m_pend = 1'b0;
            e_wd = 0; e_dac = 0; e_clip = 1'b0;
        end else begin
            e_wd = write_zero ? 0 : m_frame_in;
            if (pulse) m_frame_in = m_in_hold;
            if (m_pend) begin
                e_dac   = clamp16(m_sum);
                e_clip  = (e_dac != m_sum);
                e_valid = 1'b1;
                m_pend  = 1'b0;
                if (pulse) start_frame();
            end else if (m_open) begin
                if (hit) m_sum += rd;
                if (mix_data) begin
                    m_pend = 1'b1;
                    m_open = 1'b0;
                end else if (pulse) begin
                    e_ovr = 1'b1;
                    start_frame();
                end
            end else if (pulse) begin
                start_frame();
            end
            if (adc_valid) m_in_hold = int'($signed(adc_sample));
        end
        @(posedge clk_100MHz);
        #1;
        check("write_data", int'($signed(write_data)), e_wd);
        check("dac_sample", int'($signed(dac_sample)), e_dac);
        check("dac_valid",  int'(dac_valid), int'(e_valid));
        check("clip",       int'(clip),      int'(e_clip));
        check("overrun",    int'(overrun),   int'(e_ovr));
    endtask

    task automatic idle_inputs();
        rst = 1'b0; pulse = 1'b0; adc_valid = 1'b0; data_ready = 1'b0;
        mix_data = 1'b0; write_zero = 1'b0; mem_bank = 4'd0; read_data = '0;
    endtask

    task automatic do_pulse();
        pulse = 1'b1; step(); pulse = 1'b0;
    endtask

    task automatic read_bank(input int b, input int v);
        mem_bank = 4'(b); read_data = DATA_W'(v); data_ready = 1'b1;
        step();
        data_ready = 1'b0;
    endtask

    task automatic do_mix();
        mix_data = 1'b1; step(); mix_data = 1'b0;
        step();
    endtask

    task automatic load_adc(input int v);
        adc_sample = DATA_W'(v); adc_valid = 1'b1; step(); adc_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        adc_sample = '0; monitor_en = 1'b0; playing = '0; recording = '0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("reset_dac", int'(dac_sample), 0);
        step();

        // three banks playing, monitor off
        playing = 16'h8021;
        do_pulse(); step(); step();
        read_bank(0, 1000); read_bank(5, -300); read_bank(15, 50);
        do_mix();
        check("tp1_dac", int'($signed(dac_sample)), 750);
        check("tp1_valid", int'(dac_valid), 1);
        step();
        check("tp1_valid_drop", int'(dac_valid), 0);

        // positive and negative full-scale saturation
        monitor_en = 1'b1; playing = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            int v;
            v = (k == 0) ? 32767 : -32768;
            load_adc(v);
            do_pulse(); step(); step();
            for (int b = 0; b < 16; b++) read_bank(b, v);
            do_mix();
            check("tp2_dac", int'($signed(dac_sample)), v);
            check("tp2_clip", int'(clip), 1);
            step();
        end

        // record priority, idle banks ignored, write data path
        monitor_en = 1'b0; playing = 16'h0008; recording = 16'h0008;
        load_adc(16'h0A0A);
        do_pulse(); step(); step();
        check("tp3_wd", int'(write_data), 16'h0A0A);
        read_bank(3, 16'h1234); read_bank(7, 16'h5A5A); read_bank(9, -777);
        write_zero = 1'b1; step();
        check("tp3_wz", int'(write_data), 0);
        write_zero = 1'b0;
        do_mix();
        check("tp3_dac", int'($signed(dac_sample)), 0);
        check("tp3_clip", int'(clip), 0);
        recording = '0; playing = 16'h0001;

        // overrun drops the first frame
        do_pulse(); step(); step();
        read_bank(0, 100);
        do_pulse();
        check("tp4_ovr", int'(overrun), 1);
        step();
        check("tp4_ovr_drop", int'(overrun), 0);
        read_bank(0, 7);
        do_mix();
        check("tp4_dac", int'($signed(dac_sample)), 7);

        // pulse and mix_data coincide
        do_pulse(); step(); step();
        read_bank(0, 20);
        pulse = 1'b1; mix_data = 1'b1; step(); pulse = 1'b0; mix_data = 1'b0;
        check("tp4_no_ovr", int'(overrun), 0);
        step();
        check("tp4b_dac", int'($signed(dac_sample)), 20);
        check("tp4b_valid", int'(dac_valid), 1);
        for (int i = 0; i < 4; i++) step();

        // reset mid-frame aborts accumulation
        playing = 16'h0003;
        do_pulse(); step(); step();
        read_bank(0, 300); read_bank(1, 400);
        rst = 1'b1; step(); rst = 1'b0;
        check("tp5_rst_dac", int'(dac_sample), 0);
        mix_data = 1'b1; step(); mix_data = 1'b0;
        step();
        check("tp5_no_valid", int'(dac_valid), 0);
        do_pulse(); step(); step();
        read_bank(1, -5);
        do_mix();
        check("tp5_dac", int'($signed(dac_sample)), -5);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            pulse      = ($urandom_range(0, 9) == 0);
            mix_data   = ($urandom_range(0, 7) == 0);
            data_ready = ($urandom_range(0, 1) == 0);
            adc_valid  = ($urandom_range(0, 3) == 0);
            write_zero = ($urandom_range(0, 7) == 0);
            adc_sample = DATA_W'($urandom);
            mem_bank   = 4'($urandom);
            case ($urandom_range(0, 3))
                0: read_data = 16'h7FFF;
                1: read_data = 16'h8000;
                default: read_data = DATA_W'($urandom);
            endcase
            if ($urandom_range(0, 31) == 0) begin
                playing    = 16'($urandom);
                recording  = 16'($urandom) & 16'($urandom);
                monitor_en = 1'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
